// File: rtl/fpu_result_queue.sv
// Result queue between the combinational double-precision FPU and writeback, with sticky exception flags.
// Latency: one cycle from enqueue to out_valid on an empty queue; no bypass path.
// Backpressure: in_ready = !full from registered count; a same-cycle dequeue raises it only next cycle.
module fpu_result_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_result,
    input  logic [4:0]               in_flags,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_result,
    output logic [4:0]               out_flags,
    output logic [TAG_WIDTH-1:0]     out_tag,
    input  logic                     sticky_clr,
    output logic [4:0]               sticky,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0]          result;
        logic [4:0]           flags;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [4:0]         sticky_q;
    logic [4:0]         sticky_d;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        in_ready  = !full;
        out_valid = !empty;
        enq       = in_valid && in_ready;
        deq       = out_valid && out_ready;
    end

    // Storage is never reset, so the head is masked while the queue is empty.
    always_comb begin
        head = empty ? '0 : mem[rd_ptr];
        out_result = head.result;
        out_flags  = head.flags;
        out_tag    = head.tag;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{result: in_result, flags: in_flags, tag: in_tag};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Retiring flags are OR'd in after the clear, so a same-cycle clear never loses them.
    always_comb begin
        sticky_d = (sticky_clr ? 5'b0 : sticky_q) | (deq ? head.flags : 5'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign count  = count_q;
    assign sticky = sticky_q;

endmodule
